// File: rtl/mult_pkg.sv
// Shared state encoding and default sizing for the block-run
// multiplier host and its result checker.
package mult_pkg;

  localparam int LOGDEPTH_DEF = 6;
  localparam int WIDTH_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT_FULL,
    ST_READ_REQ,
    ST_COLLECT,
    ST_DONE
  } mult_host_state_t;

endpackage

// File: rtl/mult_host_chk.sv
// Regenerates the expected product for a captured word and
// reports a registered mismatch pulse together with its index.
module mult_host_chk
  import mult_pkg::*;
#(
  parameter int LOGDEPTH = LOGDEPTH_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         seed_a,
  input  logic [15:0]         seed_b,
  input  logic                cap_valid,
  input  logic [LOGDEPTH-1:0] cap_idx,
  input  logic [WIDTH-1:0]    cap_word,
  output logic                mis_pulse,
  output logic [LOGDEPTH-1:0] mis_idx
);

  logic [15:0]         op_a;
  logic [15:0]         op_b;
  logic [31:0]         prod;
  logic [WIDTH-1:0]    exp_word;
  logic                mis_d, mis_q;
  logic [LOGDEPTH-1:0] idx_d, idx_q;

  always_comb begin
    op_a     = seed_a + 16'(cap_idx);
    op_b     = seed_b - 16'(cap_idx);
    prod     = 32'(op_a) * 32'(op_b);
    exp_word = WIDTH'(prod);
    mis_d    = cap_valid && (cap_word != exp_word);
    idx_d    = cap_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
      idx_q <= '0;
    end else begin
      mis_q <= mis_d;
      idx_q <= idx_d;
    end
  end

  assign mis_pulse = mis_q;
  assign mis_idx   = idx_q;

endmodule

// File: rtl/mult_block_host.sv
// Host that feeds a block of operand pairs to a multiplier,
// reads the result block back and checks every word.
module mult_block_host
  import mult_pkg::*;
#(
  parameter int LOGDEPTH = LOGDEPTH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           seed_a,
  input  logic [15:0]           seed_b,
  output logic                  EN_mult,
  output logic [15:0]           mult_input0,
  output logic [15:0]           mult_input1,
  input  logic                  RDY_mult,
  output logic                  EN_blockRead,
  input  logic                  VALID_memVal,
  input  logic [WIDTH-1:0]      memVal_data,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH+LOGDEPTH-1:0] result_sum,
  output logic [LOGDEPTH:0]     mismatch_cnt,
  output logic [LOGDEPTH-1:0]   first_bad_idx,
  output logic                  timeout_err
);

  localparam int DEPTH = 2 ** LOGDEPTH;
  localparam int CW    = LOGDEPTH + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SW    = WIDTH + LOGDEPTH;

  mult_host_state_t    state_q, state_d;
  logic [15:0]         sa_q, sa_d;
  logic [15:0]         sb_q, sb_d;
  logic [CW-1:0]       k_q, k_d;
  logic [CW-1:0]       j_q, j_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [CW-1:0]       mism_q, mism_d;
  logic [LOGDEPTH-1:0] fbad_q, fbad_d;
  logic                terr_q, terr_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [TW-1:0]       tinc;
  logic                tmo;
  logic                low_q, low_d;
  logic                cap;
  logic                mis_pulse;
  logic [LOGDEPTH-1:0] mis_idx;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    k_d     = k_q;
    j_d     = j_q;
    sum_d   = sum_q;
    mism_d  = mism_q;
    fbad_d  = fbad_q;
    terr_d  = terr_q;
    tcnt_d  = '0;
    low_d   = 1'b0;
    cap     = 1'b0;
    tinc    = tcnt_q + TW'(1);
    tmo     = (tinc == TW'(TIMEOUT));

    if (mis_pulse) begin
      mism_d = mism_q + CW'(1);
      if (mism_q == '0) fbad_d = mis_idx;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FEED;
          sa_d    = seed_a;
          sb_d    = seed_b;
          k_d     = '0;
          j_d     = '0;
          sum_d   = '0;
          mism_d  = '0;
          fbad_d  = '0;
          terr_d  = 1'b0;
        end
      end
      ST_FEED: begin
        if (RDY_mult) begin
          k_d = k_q + CW'(1);
          if (k_d == CW'(DEPTH)) state_d = ST_WAIT_FULL;
        end else if (k_q != '0) begin
          state_d = ST_WAIT_FULL;
        end else if (tmo) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tinc;
        end
      end
      ST_WAIT_FULL: begin
        low_d = !RDY_mult;
        if (!RDY_mult && low_q) begin
          state_d = ST_READ_REQ;
        end else if (tmo) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tinc;
        end
      end
      ST_READ_REQ: begin
        if (VALID_memVal) begin
          cap     = 1'b1;
          sum_d   = sum_q + SW'(memVal_data);
          j_d     = CW'(1);
          state_d = ST_COLLECT;
        end else if (tmo) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tinc;
        end
      end
      ST_COLLECT: begin
        // One extra cycle after the last word lets its compare retire
        if (j_q == CW'(DEPTH) || !VALID_memVal) begin
          state_d = ST_DONE;
        end else begin
          cap   = 1'b1;
          sum_d = sum_q + SW'(memVal_data);
          j_d   = j_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      k_q     <= '0;
      j_q     <= '0;
      sum_q   <= '0;
      mism_q  <= '0;
      fbad_q  <= '0;
      terr_q  <= 1'b0;
      tcnt_q  <= '0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      k_q     <= k_d;
      j_q     <= j_d;
      sum_q   <= sum_d;
      mism_q  <= mism_d;
      fbad_q  <= fbad_d;
      terr_q  <= terr_d;
      tcnt_q  <= tcnt_d;
      low_q   <= low_d;
    end
  end

  mult_host_chk #(
    .LOGDEPTH(LOGDEPTH),
    .WIDTH   (WIDTH)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .seed_a   (sa_q),
    .seed_b   (sb_q),
    .cap_valid(cap),
    .cap_idx  (j_q[LOGDEPTH-1:0]),
    .cap_word (memVal_data),
    .mis_pulse(mis_pulse),
    .mis_idx  (mis_idx)
  );

  assign EN_mult       = (state_q == ST_FEED);
  assign mult_input0   = EN_mult ? sa_q + 16'(k_q) : '0;
  assign mult_input1   = EN_mult ? sb_q - 16'(k_q) : '0;
  assign EN_blockRead  = (state_q == ST_READ_REQ);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign result_sum    = sum_q;
  assign mismatch_cnt  = mism_q;
  assign first_bad_idx = fbad_q;
  assign timeout_err   = terr_q;

endmodule
